benes_cfg_loader: RTL and testbench

BENES_CFG_LOADER -- requirements
Module: benes_cfg_loader

---
 rtl/benes_cfg_loader.sv | 122 ++++++++++++
 tb/tb_benes_cfg_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader
//   Double-buffered switch-word loader for a Benes permutation network.
//   A beat stream fills a shadow bank one stage word per beat. A complete,
//   well-formed permutation is moved into the active bank in a single edge,
//   but only once the network reports no data in flight. The active bank
//   drives the network switches directly.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_valid    configuration beat valid
//   cfg_ready    loader accepts a beat this cycle (decoded from state only)
//   cfg_data     switch word for the current stage; bit k set = switch k cross
//   cfg_last     final beat of one permutation
//   net_hold     network busy; a pending swap waits while high
//   switch_set   active switch words, index 0 = first stage
//   cfg_applied  one-cycle pulse in the first cycle a new config is active
//   cfg_err      one-cycle pulse after a malformed permutation is discarded
module benes_cfg_loader #(
  parameter int STAGE_NUM  = 9,
  parameter int SWITCH_NUM = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [SWITCH_NUM-1:0]                  cfg_data,
  input  logic                                   cfg_last,
  input  logic                                   net_hold,
  output logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]   switch_set,
  output logic                                   cfg_applied,
  output logic                                   cfg_err
);

  // A single-stage network still needs a one-bit counter.
  localparam int CNT_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STAGE_NUM - 1);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]                                state_r;
  logic [0:0]                                state_nxt_s;
  logic [CNT_W-1:0]                          cnt_r;
  logic [CNT_W-1:0]                          cnt_nxt_s;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]      shadow_r;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]      shadow_nxt_s;
  logic [STAGE_NUM-1:0][SWITCH_NUM-1:0]      active_nxt_s;
  logic                                      applied_nxt_s;
  logic                                      err_nxt_s;
  logic                                      at_last_s;

  // Ready is the state itself, so it never depends on cfg_valid.
  assign cfg_ready = (state_r == LOAD);
  assign at_last_s = (cnt_r == LAST_IDX);

  // Next-state decode: beat acceptance, framing check and bank swap.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    shadow_nxt_s  = shadow_r;
    active_nxt_s  = switch_set;
    applied_nxt_s = 1'b0;
    err_nxt_s     = 1'b0;
    case (state_r)
      LOAD: begin
        if (cfg_valid) begin
          shadow_nxt_s[cnt_r] = cfg_data;
          if (at_last_s && cfg_last) begin
            // Complete permutation; cnt holds until the swap.
            state_nxt_s = PEND;
          end else if (at_last_s || cfg_last) begin
            // Early or missing cfg_last: drop the frame, keep active bank.
            err_nxt_s = 1'b1;
            cnt_nxt_s = CNT_ZERO;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      PEND: begin
        if (!net_hold) begin
          // Whole-bank copy: the network never sees a mixed configuration.
          active_nxt_s  = shadow_r;
          applied_nxt_s = 1'b1;
          state_nxt_s   = LOAD;
          cnt_nxt_s     = CNT_ZERO;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: begin
        state_nxt_s = LOAD;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, banks and pulse outputs; reset clears everything to identity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= LOAD;
      cnt_r       <= CNT_ZERO;
      shadow_r    <= {(STAGE_NUM*SWITCH_NUM){1'b0}};
      switch_set  <= {(STAGE_NUM*SWITCH_NUM){1'b0}};
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      shadow_r    <= shadow_nxt_s;
      switch_set  <= active_nxt_s;
      cfg_applied <= applied_nxt_s;
      cfg_err     <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb_benes_cfg_loader
//   Directed bench for benes_cfg_loader. A frame-level model (a queue of
//   received words plus a pending flag) predicts ready, pulses and the
//   active bank every cycle; directed steps add literal expectations.
module tb_benes_cfg_loader;

  localparam int ST = 9;
  localparam int SW = 16;

  logic                    clk;
  logic                    rst_n;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [SW-1:0]           cfg_data;
  logic                    cfg_last;
  logic                    net_hold;
  logic [ST-1:0][SW-1:0]   switch_set;
  logic                    cfg_applied;
  logic                    cfg_err;

  benes_cfg_loader #(.STAGE_NUM(ST), .SWITCH_NUM(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .net_hold(net_hold),
    .switch_set(switch_set), .cfg_applied(cfg_applied), .cfg_err(cfg_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_app = 0;
  int n_errp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [ST*SW-1:0] act,
                         input logic [ST*SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [SW-1:0]         m_q[$];
  logic                  m_pend;
  logic [ST-1:0][SW-1:0] m_act;
  logic                  m_app;
  logic                  m_err;

  task automatic model_step();
    if (!rst_n) begin
      m_q.delete();
      m_pend = 1'b0;
      m_act  = '0;
      m_app  = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_app = 1'b0;
      m_err = 1'b0;
      if (m_pend) begin
        if (!net_hold) begin
          for (int i = 0; i < ST; i++) m_act[i] = m_q[i];
          m_q.delete();
          m_pend = 1'b0;
          m_app  = 1'b1;
        end
      end else if (cfg_valid) begin
        m_q.push_back(cfg_data);
        if (m_q.size() == ST && cfg_last) begin
          m_pend = 1'b1;
        end else if (m_q.size() == ST || cfg_last) begin
          m_err = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  initial begin
    m_pend = 1'b0; m_act = '0; m_app = 1'b0; m_err = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Per-cycle comparison, sampled 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk_bit("cyc_ready", cfg_ready, !m_pend);
      chk_bit("cyc_applied", cfg_applied, m_app);
      chk_bit("cyc_err", cfg_err, m_err);
      chk_vec("cyc_switch_set", switch_set, m_act);
      if (cfg_applied) n_app++;
      if (cfg_err) n_errp++;
    end
  end

  // ---------------- stimulus ----------------
  logic [ST-1:0][SW-1:0] w1, w2, w3, w4, w5;

  task automatic send_frame(input logic [ST-1:0][SW-1:0] w, input int n,
                            input int last_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = w[i];
      cfg_last  = (i == last_at);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  int a0, e0, idx, guard;

  initial begin
    for (int i = 0; i < ST; i++) begin
      w1[i] = 16'h0001 << i;
      w2[i] = 16'hA5A0 | 16'(i);
      w3[i] = 16'hF00F ^ (16'h0101 << i);
      w4[i] = ~(16'h0001 << i);
      w5[i] = 16'h8000 >> i;
    end
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = 16'h0000;
    cfg_last = 1'b0; net_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_bit("rst_ready", cfg_ready, 1'b1);
    chk_vec("rst_switch_zero", switch_set, '0);

    // Idle after reset: no pulses for 20 cycles.
    a0 = n_app; e0 = n_errp;
    repeat (20) @(negedge clk);
    chk_int("idle_applied_cnt", n_app - a0, 0);
    chk_int("idle_err_cnt", n_errp - e0, 0);
    chk_vec("idle_switch_zero", switch_set, '0);

    // Back-to-back load, swap one edge after the final beat.
    send_frame(w1, ST, ST - 1);
    chk_bit("b2b_pend_ready", cfg_ready, 1'b0);
    chk_bit("b2b_not_yet", cfg_applied, 1'b0);
    @(negedge clk);
    chk_bit("b2b_applied", cfg_applied, 1'b1);
    chk_bit("b2b_ready_back", cfg_ready, 1'b1);
    chk_vec("b2b_words", switch_set, w1);
    chk_vec("model_pin_w1", m_act, w1);

    // Held swap: 50 cycles of net_hold, then release.
    net_hold = 1'b1;
    send_frame(w2, ST, ST - 1);
    a0 = n_app;
    repeat (50) @(negedge clk);
    chk_bit("hold_ready", cfg_ready, 1'b0);
    chk_vec("hold_switch_old", switch_set, w1);
    chk_int("hold_no_apply", n_app - a0, 0);
    net_hold = 1'b0;
    @(negedge clk);
    chk_bit("hold_release_applied", cfg_applied, 1'b1);
    chk_vec("hold_release_words", switch_set, w2);

    // Early cfg_last on beat 4 is discarded, then a good frame applies.
    e0 = n_errp;
    send_frame(w3, 5, 4);
    chk_bit("early_err", cfg_err, 1'b1);
    @(negedge clk);
    chk_int("early_err_once", n_errp - e0, 1);
    chk_vec("early_switch_kept", switch_set, w2);
    send_frame(w3, ST, ST - 1);
    @(negedge clk);
    chk_bit("after_err_applied", cfg_applied, 1'b1);
    chk_vec("after_err_words", switch_set, w3);

    // Missing cfg_last: error after beat 8.
    e0 = n_errp;
    send_frame(w1, ST, -1);
    chk_bit("nolast_err", cfg_err, 1'b1);
    chk_vec("nolast_switch_kept", switch_set, w3);

    // Randomly gapped valid still loads the exact words.
    idx = 0; guard = 0;
    while (idx < ST && guard < 500) begin
      @(negedge clk);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_data  = w4[idx];
      cfg_last  = (idx == ST - 1);
      if (cfg_valid) idx++;
      guard++;
    end
    @(negedge clk);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    a0 = n_app;
    repeat (3) @(negedge clk);
    chk_int("gap_applied_once", n_app - a0, 1);
    chk_vec("gap_words", switch_set, w4);

    // Reset during beat 5 clears immediately and discards the frame.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_data = w5[i]; cfg_last = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_vec("midrst_switch_zero", switch_set, '0);
    chk_bit("midrst_ready", cfg_ready, 1'b1);
    chk_bit("midrst_applied", cfg_applied, 1'b0);
    chk_bit("midrst_err", cfg_err, 1'b0);
    @(negedge clk);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    a0 = n_app; e0 = n_errp;
    repeat (10) @(negedge clk);
    chk_int("midrst_no_apply", n_app - a0, 0);
    chk_int("midrst_no_err", n_errp - e0, 0);
    send_frame(w5, ST, ST - 1);
    @(negedge clk);
    chk_bit("restart_applied", cfg_applied, 1'b1);
    chk_vec("restart_words", switch_set, w5);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
